// File: rtl/ternary_serial_adder_ctrl.sv
// Digit-serial unsigned ternary adder: one shared digit adder walks the operands
// LSD-first, one digit per RUN cycle, and holds the result in DONE until acknowledged.
module ternary_serial_adder_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  input  logic           cIn,
  input  logic           resultAck,
  output logic           busy,
  output logic           resultValid,
  output logic [2*N-1:0] sum,
  output logic           cOut,
  output logic           overflow,
  output logic           invalid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
  localparam logic [2*N-1:0] DIG_MASK = (2*N)'(2'b11);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [2*N-1:0] r_a;
  logic [2*N-1:0] r_b;
  logic [2*N-1:0] r_sum;
  logic [IW-1:0]  r_idx;
  logic           r_carry;
  logic           r_cout;
  logic           r_ovf;
  logic           r_inv;

  logic           w_accept;
  logic           w_last;
  logic [2*N-1:0] w_a_sh;
  logic [2*N-1:0] w_b_sh;
  logic [1:0]     w_a_dig;
  logic [1:0]     w_b_dig;
  logic [1:0]     w_a_val;
  logic [1:0]     w_b_val;
  logic           w_dig_bad;
  logic [2:0]     w_t;
  logic           w_carry_next;
  logic [1:0]     w_sum_dig;
  logic [2*N-1:0] w_shift;
  logic [2*N-1:0] w_sum_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

  // NOTE: next-state logic assigns its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)     w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (resultAck) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Shared digit adder: select digit r_idx, treat 2'b11 as zero, add with carry.
  assign w_shift   = (2*N)'({r_idx, 1'b0});
  assign w_a_sh    = r_a >> w_shift;
  assign w_b_sh    = r_b >> w_shift;
  assign w_a_dig   = w_a_sh[1:0];
  assign w_b_dig   = w_b_sh[1:0];
  assign w_dig_bad = (w_a_dig == 2'b11) || (w_b_dig == 2'b11);
  assign w_a_val   = (w_a_dig == 2'b11) ? 2'b00 : w_a_dig;
  assign w_b_val   = (w_b_dig == 2'b11) ? 2'b00 : w_b_dig;
  assign w_t       = {1'b0, w_a_val} + {1'b0, w_b_val} + {2'b00, r_carry};
  assign w_carry_next = (w_t >= 3'd3);
  assign w_sum_dig    = w_carry_next ? 2'(w_t - 3'd3) : w_t[1:0];
  assign w_sum_next   = (r_sum & ~(DIG_MASK << w_shift))
                      | ((2*N)'(w_sum_dig) << w_shift);

  // The index stops at LAST_IDX on the final digit, so it never wraps mid-operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cIn;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum   <= w_sum_next;
      r_carry <= w_carry_next;
      r_inv   <= r_inv | w_dig_bad;
      if (w_last) begin
        r_cout <= w_carry_next;
        r_ovf  <= w_carry_next ^ r_carry;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign resultValid = (r_state == S_DONE);
  assign sum         = r_sum;
  assign cOut        = r_cout;
  assign overflow    = r_ovf;
  assign invalid     = r_inv;

endmodule

// File: tb/tb_ternary_serial_adder_ctrl.sv
// Scoreboard bench for ternary_serial_adder_ctrl (N=4): expected results are
// queued when an operation is issued and compared when resultValid rises.
module tb_ternary_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cIn;
  logic         resultAck;
  logic         busy;
  logic         resultValid;
  logic [W-1:0] sum;
  logic         cOut;
  logic         overflow;
  logic         invalid;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         inv;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_vec = 0;
  int   n_err = 0;

  ternary_serial_adder_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .cIn         (cIn),
    .resultAck   (resultAck),
    .busy        (busy),
    .resultValid (resultValid),
    .sum         (sum),
    .cOut        (cOut),
    .overflow    (overflow),
    .invalid     (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Arithmetic model: convert operands to integers, add, and re-encode base 3.
  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    exp_t e;
    int va = 0, vb = 0, pw = 1, lowa = 0, lowb = 0, ptop = 1, total, full, sv;
    logic [1:0] da, db;
    e.inv = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        lowa = va; lowb = vb; ptop = pw;
      end
      da = ai[2*i +: 2];
      db = bi[2*i +: 2];
      if (da == 2'b11) begin e.inv = 1'b1; da = 2'b00; end
      if (db == 2'b11) begin e.inv = 1'b1; db = 2'b00; end
      va += int'(da) * pw;
      vb += int'(db) * pw;
      pw *= 3;
    end
    full   = ptop * 3;
    total  = va + vb + int'(ci);
    e.cout = (total >= full);
    e.ovf  = e.cout ^ ((lowa + lowb + int'(ci)) >= ptop);
    sv     = total % full;
    e.sum  = '0;
    for (int i = 0; i < N; i++) begin
      e.sum[2*i +: 2] = 2'(sv % 3);
      sv = sv / 3;
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input bit hold_start);
    a = ai; b = bi; cIn = ci; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cIn = 1'($urandom);
  endtask

  // Scoreboard drain: wait for resultValid, check latency, pop and compare.
  task automatic sb_collect(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (resultValid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== N) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, lat, N);
    end
    if (q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard: got empty queue want one entry", tag);
      return;
    end
    e = q.pop_front();
    last_exp = e;
    n_vec++;
    if (sum !== e.sum) begin
      n_err++; $display("FAIL %s sum: got %h want %h", tag, sum, e.sum);
    end
    n_vec++;
    if (cOut !== e.cout) begin
      n_err++; $display("FAIL %s cOut: got %b want %b", tag, cOut, e.cout);
    end
    n_vec++;
    if (overflow !== e.ovf) begin
      n_err++; $display("FAIL %s overflow: got %b want %b", tag, overflow, e.ovf);
    end
    n_vec++;
    if (invalid !== e.inv) begin
      n_err++; $display("FAIL %s invalid: got %b want %b", tag, invalid, e.inv);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_done: got %b want 1", tag, busy);
    end
  endtask

  task automatic ack(input string tag);
    resultAck = 1'b1;
    @(posedge clk); #1;
    resultAck = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || resultValid !== 1'b0) begin
      n_err++;
      $display("FAIL %s ack: got busy=%b valid=%b want busy=0 valid=0", tag, busy, resultValid);
    end
    n_vec++;
    if ({sum, cOut, overflow, invalid} !== {last_exp.sum, last_exp.cout, last_exp.ovf, last_exp.inv}) begin
      n_err++;
      $display("FAIL %s idle_retain: got %h/%b%b%b want %h/%b%b%b", tag, sum, cOut, overflow,
               invalid, last_exp.sum, last_exp.cout, last_exp.ovf, last_exp.inv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; resultAck = 1'b0; a = '0; b = '0; cIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({busy, resultValid, sum, cOut, overflow, invalid} !== '0) begin
      n_err++;
      $display("FAIL reset: got busy=%b valid=%b sum=%h c=%b o=%b i=%b want all 0",
               busy, resultValid, sum, cOut, overflow, invalid);
    end
  endtask

  task automatic test_spec_vectors();
    logic [W-1:0] va[4] = '{8'h01, 8'hAA, 8'h80, 8'h03};
    logic [W-1:0] vb[4] = '{8'h02, 8'hAA, 8'h40, 8'h01};
    logic         vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_t         ve[4] = '{'{8'h04, 1'b0, 1'b0, 1'b0},
                            '{8'hAA, 1'b1, 1'b0, 1'b0},
                            '{8'h00, 1'b1, 1'b1, 1'b0},
                            '{8'h01, 1'b0, 1'b0, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      q.push_back(ve[i]);
      issue(va[i], vb[i], vc[i], 1'b0);
      sb_collect($sformatf("vec%0d", i));
      ack($sformatf("vec%0d", i));
    end
    // A clean operation after the invalid one must clear the sticky flag.
    q.push_back('{8'h06, 1'b0, 1'b0, 1'b0});
    issue(8'h05, 8'h01, 1'b0, 1'b0);
    sb_collect("inv_clear");
    ack("inv_clear");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < N; i++) begin
        ra[2*i +: 2] = 2'($urandom_range(0, (n % 3 == 0) ? 3 : 2));
        rb[2*i +: 2] = 2'($urandom_range(0, 2));
      end
      rc = 1'($urandom);
      q.push_back(model(ra, rb, rc));
      issue(ra, rb, rc, 1'b0);
      resultAck = 1'b1;  // acknowledge during RUN must be ignored
      @(posedge clk); #1;
      resultAck = 1'b0;
      // one RUN edge already consumed above
      begin
        int   lat;
        exp_t e;
        lat = 1;
        while (resultValid !== 1'b1 && lat < 20) begin
          @(posedge clk); #1;
          lat++;
        end
        n_vec++;
        if (lat !== N) begin
          n_err++; $display("FAIL rand%0d latency: got %0d want %0d", n, lat, N);
        end
        e = q.pop_front();
        last_exp = e;
        n_vec++;
        if ({sum, cOut, overflow, invalid} !== {e.sum, e.cout, e.ovf, e.inv}) begin
          n_err++;
          $display("FAIL rand%0d result a=%h b=%h c=%b: got %h/%b%b%b want %h/%b%b%b", n, ra, rb, rc,
                   sum, cOut, overflow, invalid, e.sum, e.cout, e.ovf, e.inv);
        end
      end
      ack($sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid_run();
    a = 8'h55; b = 8'h55; cIn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;   // first RUN edge writes digit 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || resultValid !== 1'b0 || sum !== '0 || cOut !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b valid=%b sum=%h c=%b want 0/0/00/0",
               busy, resultValid, sum, cOut);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (resultValid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_quiet: got valid=%b busy=%b want 0/0", resultValid, busy);
      end
    end
    q.push_back(model(8'h01, 8'h02, 1'b0));
    issue(8'h01, 8'h02, 1'b0, 1'b0);
    sb_collect("after_reset");
    ack("after_reset");
  endtask

  task automatic test_start_held();
    q.push_back(model(8'h12, 8'h21, 1'b1));
    issue(8'h12, 8'h21, 1'b1, 1'b1);
    sb_collect("held");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (resultValid !== 1'b1 || sum !== last_exp.sum) begin
        n_err++;
        $display("FAIL held_stable: got valid=%b sum=%h want 1/%h", resultValid, sum, last_exp.sum);
      end
    end
    ack("held_ack_with_start");
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || resultValid !== 1'b0) begin
        n_err++;
        $display("FAIL held_single_op: got busy=%b valid=%b want 0/0", busy, resultValid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_reset_mid_run();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ternary_serial_adder_ctrl.md
TERNARY_SERIAL_ADDER_CTRL -- requirements
Module: ternary_serial_adder_ctrl

Interface
REQ-001: Parameter N, default 4, sets operand width in ternary digits (N >= 1); each digit occupies 2 bits, LSD in bits [1:0].
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  operation request, sampled only in IDLE.
REQ-005: a  input  2N  operand A, unsigned ternary (00=0, 01=1, 10=2, 11=invalid).
REQ-006: b  input  2N  operand B, same encoding.
REQ-007: cIn  input  1  carry into digit 0.
REQ-008: resultAck  input  1  consumer acknowledge of a held result.
REQ-009: busy  output  1  high in RUN and DONE.
REQ-010: resultValid  output  1  high only in DONE.
REQ-011: sum  output  2N  registered result digits.
REQ-012: cOut  output  1  carry out of digit N-1.
REQ-013: overflow  output  1  carry out of digit N-1 XOR carry into digit N-1.
REQ-014: invalid  output  1  at least one operand digit of the current operation was 2'b11.

Function
REQ-015: FSM states IDLE, RUN, DONE; one digit adder instance shared over all digit positions, one digit per RUN cycle.
REQ-016: IDLE with start=1 at an edge: capture a, b, cIn into internal registers; clear sum, cOut, overflow, invalid; digit index = 0; carry register = cIn; go to RUN.
REQ-017: Each RUN edge processes digit i: t = a_i + b_i + carry; sum digit i = t mod 3; carry = (t >= 3); index increments.
REQ-018: Operand digit 2'b11 is used as value 0 and sets invalid (sticky until next accepted start).
REQ-019: At the edge processing digit N-1: cOut = new carry; overflow = new carry XOR carry entering digit N-1 (equals cIn when N = 1); go to DONE.
REQ-020: Latency: resultValid rises exactly N edges after the edge that accepted start.
REQ-021: DONE holds sum, cOut, overflow, invalid stable; resultAck=1 at an edge returns to IDLE; outputs retain values in IDLE until the next accepted start.
REQ-022: start in RUN or DONE is ignored, including start and resultAck asserted together in DONE; start must be reasserted in IDLE.
REQ-023: resultAck outside DONE is ignored.
REQ-024: Changes on a, b, cIn after acceptance do not affect the operation in progress.
REQ-025: Digit index counter wide enough for N-1; never wraps within an operation.

Reset
REQ-026: rst=1 at an edge forces IDLE, busy=0, resultValid=0, sum=0, cOut=0, overflow=0, invalid=0, carry and index=0, regardless of state.
REQ-027: rst has priority over start and resultAck in the same cycle; reset mid-RUN aborts the operation with no partial result marked valid.

Verification (N=4)
REQ-028: a=8'h01, b=8'h02, cIn=0, start -> after 4 edges resultValid=1, sum=8'h04, cOut=0, overflow=0, invalid=0.
REQ-029: a=8'hAA, b=8'hAA, cIn=1 -> sum=8'hAA, cOut=1, overflow=0.
REQ-030: a=8'h80, b=8'h40, cIn=0 -> sum=8'h00, cOut=1, overflow=1.
REQ-031: a=8'h03, b=8'h01, cIn=0 -> sum=8'h01, invalid=1; next operation with valid digits -> invalid=0.
REQ-032: rst asserted on the 2nd RUN cycle -> next cycle busy=0, resultValid=0, sum=0; a following start completes correctly in 4 cycles.
REQ-033: start held high through RUN/DONE, then resultAck with start in DONE -> one operation only, return to IDLE, busy=0; inputs changed mid-RUN do not alter sum.
